// File: rtl/phase_acc_par.sv
// Parallel multi-lane NCO phase generator: LANES consecutive samples per clock, start offset, valid/ready config.
// Define PHASE_ACC_SWEEP_EN to build the repeating linear frequency sweep (chirp) and sweep_done_o pulses.

module phase_acc_lane #(
    parameter int PHASE_W = 32,
    parameter int K       = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PHASE_W-1:0] acc,
    input  logic [PHASE_W-1:0] inc,
    output logic [PHASE_W-1:0] phase
);
    // Constant multiply as a shift-and-add chain; K is at most 15.
    function automatic logic [PHASE_W-1:0] mul_const(input logic [PHASE_W-1:0] x, input logic [4:0] k);
        logic [PHASE_W-1:0] r;
        r = '0;
        for (int b = 0; b < 5; b++)
            if (k[b]) r = r + (x << b);
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) phase <= '0;
        else       phase <= acc + mul_const(inc, 5'(K));
    end
endmodule

module phase_acc_par #(
    parameter int LANES   = 4,
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [PHASE_W-1:0]       cfg_inc_i,
    input  logic [PHASE_W-1:0]       cfg_step_i,
    input  logic [CNT_W-1:0]         cfg_len_i,
    input  logic [PHASE_W-1:0]       cfg_off_i,
    input  logic                     sync_i,
    output logic [LANES*PHASE_W-1:0] phase_o,
    output logic                     valid_o,
    output logic                     sweep_done_o
);
    typedef enum logic [1:0] {IDLE, TONE, SWEEP} state_t;

    function automatic logic [PHASE_W-1:0] mul_const(input logic [PHASE_W-1:0] x, input logic [4:0] k);
        logic [PHASE_W-1:0] r;
        r = '0;
        for (int b = 0; b < 5; b++)
            if (k[b]) r = r + (x << b);
        return r;
    endfunction

    state_t                        state;
    logic [PHASE_W-1:0]            acc, inc;
    logic [PHASE_W-1:0]            act_inc0, act_off, sh_inc0, sh_off;
    logic                          pending, accept, apply, valid_q;
    logic [LANES-1:0][PHASE_W-1:0] lane_ph;

    assign accept      = cfg_valid_i && !pending;
    assign cfg_ready_o = !pending;
    assign valid_o     = valid_q;
    assign phase_o     = lane_ph;

`ifdef PHASE_ACC_SWEEP_EN
    logic [PHASE_W-1:0] act_step, sh_step;
    logic [CNT_W-1:0]   cnt, act_len, sh_len;
    logic               wrap, done_q;

    assign wrap         = (state == SWEEP) && (cnt == '0);
    // A sweep in progress only takes a new config at its wrap, keeping the chirp intact.
    assign apply        = pending && ((state != SWEEP) || wrap);
    assign sweep_done_o = done_q;
`else
    logic unused_cfg;

    assign unused_cfg   = ^{cfg_step_i, cfg_len_i};
    assign apply        = pending;
    assign sweep_done_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            inc      <= '0;
            act_inc0 <= '0;
            act_off  <= '0;
            sh_inc0  <= '0;
            sh_off   <= '0;
            pending  <= 1'b0;
            valid_q  <= 1'b0;
`ifdef PHASE_ACC_SWEEP_EN
            act_step <= '0;
            sh_step  <= '0;
            act_len  <= '0;
            sh_len   <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
`endif
        end else begin
            valid_q <= (state != IDLE);
            acc     <= acc + mul_const(inc, 5'(LANES));
            if (accept) begin
                sh_inc0 <= cfg_inc_i;
                sh_off  <= cfg_off_i;
                pending <= 1'b1;
`ifdef PHASE_ACC_SWEEP_EN
                sh_step <= cfg_step_i;
                sh_len  <= cfg_len_i;
`endif
            end
            if (apply) begin
                pending  <= 1'b0;
                act_inc0 <= sh_inc0;
                act_off  <= sh_off;
                acc      <= sh_off;
                inc      <= sh_inc0;
`ifdef PHASE_ACC_SWEEP_EN
                act_step <= sh_step;
                act_len  <= sh_len;
                cnt      <= sh_len - 1'b1;
                state    <= (sh_len != '0) ? SWEEP : TONE;
`else
                state    <= TONE;
`endif
            end else if (sync_i && state != IDLE) begin
                acc <= act_off;
                inc <= act_inc0;
`ifdef PHASE_ACC_SWEEP_EN
                cnt <= act_len - 1'b1;
            end else if (state == SWEEP) begin
                // Wrap restarts the increment but lets acc run on: phase-continuous chirp.
                if (wrap) begin
                    inc <= act_inc0;
                    cnt <= act_len - 1'b1;
                end else begin
                    inc <= inc + act_step;
                    cnt <= cnt - 1'b1;
                end
`endif
            end
`ifdef PHASE_ACC_SWEEP_EN
            done_q <= wrap;
`endif
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        phase_acc_lane #(.PHASE_W(PHASE_W), .K(k)) u_lane (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .acc   (acc),
            .inc   (inc),
            .phase (lane_ph[k])
        );
    end
endmodule

// File: tb/tb_phase_acc_par.sv
// Self-checking bench for phase_acc_par: directed scenarios plus random traffic against a sample-stream model.
`timescale 1ns/1ps
module tb_phase_acc_par;
    localparam int LANES = 4, PW = 32, CW = 16;
`ifdef PHASE_ACC_SWEEP_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i = 1'b0, cfg_valid_i = 1'b0, sync_i = 1'b0;
    logic cfg_ready_o, valid_o, sweep_done_o;
    logic [PW-1:0] cfg_inc_i = '0, cfg_step_i = '0, cfg_off_i = '0;
    logic [CW-1:0] cfg_len_i = '0;
    logic [LANES*PW-1:0] phase_o;
    int n_chk = 0, n_pass = 0;

    always #5 clk_i = ~clk_i;

    phase_acc_par #(.LANES(LANES), .PHASE_W(PW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_inc_i(cfg_inc_i), .cfg_step_i(cfg_step_i), .cfg_len_i(cfg_len_i), .cfg_off_i(cfg_off_i),
        .sync_i(sync_i), .phase_o(phase_o), .valid_o(valid_o), .sweep_done_o(sweep_done_o)
    );

    // Model: phase of the next sample plus the position within the sweep period.
    typedef struct packed {logic [PW-1:0] inc0, step; logic [CW-1:0] len; logic [PW-1:0] off;} cfg_t;
    cfg_t m_act, m_sh;
    logic m_pend;
    int m_mode;  // 0 idle, 1 tone, 2 sweep
    logic [PW-1:0] m_ph, m_idx;
    logic [LANES*PW-1:0] exp_vec;
    logic exp_valid, exp_done, exp_ready;

    function automatic logic [LANES*PW-1:0] lanes_of(input logic [PW-1:0] base, input logic [PW-1:0] inc);
        logic [LANES*PW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*PW +: PW] = base + PW'(k) * inc;
        return v;
    endfunction

    function automatic logic [PW-1:0] cur_inc();
        if (m_mode == 2) return m_act.inc0 + m_idx * m_act.step;
        if (m_mode == 1) return m_act.inc0;
        return '0;
    endfunction

    task automatic model_reset();
        m_act = '0; m_sh = '0; m_pend = 1'b0; m_mode = 0; m_ph = '0; m_idx = '0;
        exp_vec = '0; exp_valid = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic model_step();
        logic [PW-1:0] inc;
        logic wrap, acc_now, app;
        inc       = cur_inc();
        wrap      = (m_mode == 2) && (m_idx == PW'(m_act.len) - 32'd1);
        exp_vec   = lanes_of(m_ph, inc);
        exp_valid = (m_mode != 0);
        exp_done  = wrap;
        acc_now   = cfg_valid_i && !m_pend;
        app       = m_pend && (m_mode != 2 || wrap);
        m_ph      = m_ph + PW'(LANES) * inc;
        if (app) begin
            m_act = m_sh; m_ph = m_sh.off; m_idx = '0; m_pend = 1'b0;
            m_mode = (SW && m_sh.len != '0) ? 2 : 1;
        end else if (sync_i && m_mode != 0) begin
            m_ph = m_act.off; m_idx = '0;
        end else if (m_mode == 2) begin
            m_idx = wrap ? '0 : m_idx + 32'd1;
        end
        if (acc_now) begin
            m_sh.inc0 = cfg_inc_i; m_sh.step = cfg_step_i; m_sh.len = cfg_len_i; m_sh.off = cfg_off_i;
            m_pend = 1'b1;
        end
        exp_ready = !m_pend;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    // Offers a config and returns just after the edge that accepted it.
    task automatic send_cfg(input logic [PW-1:0] inc0, input logic [PW-1:0] step,
                            input logic [CW-1:0] len, input logic [PW-1:0] off);
        bit done;
        done = 1'b0;
        cfg_valid_i = 1'b1; cfg_inc_i = inc0; cfg_step_i = step; cfg_len_i = len; cfg_off_i = off;
        for (int i = 0; i < 64 && !done; i++) begin
            done = !m_pend;
            tick();
        end
        cfg_valid_i = 1'b0;
        if (!done) begin
            n_chk++;
            $display("FAIL cfg_accept_timeout: got no acceptance, want acceptance within 64 clocks");
        end
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_i = 1'b1;
        #2;
        n_chk++; if (phase_o !== '0) $display("FAIL reset_phase: got %h want 0", phase_o); else n_pass++;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_chk++; if (sweep_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", sweep_done_o); else n_pass++;
        n_chk++; if (cfg_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_ready_o); else n_pass++;
        #19 rst_i = 1'b0;
    endtask

    task automatic test_tone();
        logic [LANES*PW-1:0] want;
        want = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
        send_cfg(32'h0100_0000, '0, '0, '0);
        n_chk++; if (cfg_ready_o !== exp_ready) $display("FAIL tone_ready: got %b want %b", cfg_ready_o, exp_ready); else n_pass++;
        tick(); tick();
        n_chk++; if (phase_o !== want) $display("FAIL tone_first: got %h want %h", phase_o, want); else n_pass++;
        n_chk++; if (valid_o !== 1'b1) $display("FAIL tone_valid: got %b want 1", valid_o); else n_pass++;
        tick();
        n_chk++; if (phase_o[31:0] !== 32'h0400_0000) $display("FAIL tone_next: got %h want 04000000", phase_o[31:0]); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (phase_o !== exp_vec) $display("FAIL tone_run: got %h want %h", phase_o, exp_vec); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [LANES*PW-1:0] want;
        want = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000};
        send_cfg(32'h4000_0000, '0, '0, 32'hC000_0000);
        tick(); tick();
        n_chk++; if (phase_o !== want) $display("FAIL wrap_first: got %h want %h", phase_o, want); else n_pass++;
        tick();
        n_chk++; if (phase_o !== want) $display("FAIL wrap_return: got %h want %h", phase_o, want); else n_pass++;
    endtask

    task automatic test_sweep();
        int n_done;
        logic [PW-1:0] obs_inc, want_inc, prev_l0, prev_inc;
        n_done = 0;
        send_cfg(32'h10, 32'h1, 16'd3, '0);
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            obs_inc  = phase_o[2*PW-1:PW] - phase_o[PW-1:0];
            want_inc = SW ? 32'h10 + PW'(i % 3) : 32'h10;
            n_chk++; if (obs_inc !== want_inc) $display("FAIL sweep_inc: got %h want %h", obs_inc, want_inc); else n_pass++;
            n_chk++; if (phase_o !== exp_vec) $display("FAIL sweep_phase: got %h want %h", phase_o, exp_vec); else n_pass++;
            n_chk++; if (sweep_done_o !== exp_done) $display("FAIL sweep_done: got %b want %b", sweep_done_o, exp_done); else n_pass++;
            if (i > 0) begin
                n_chk++;
                if (phase_o[PW-1:0] !== prev_l0 + 32'd4 * prev_inc)
                    $display("FAIL sweep_continuity: got %h want %h", phase_o[PW-1:0], prev_l0 + 32'd4 * prev_inc);
                else n_pass++;
            end
            prev_l0 = phase_o[PW-1:0]; prev_inc = obs_inc;
            if (sweep_done_o === 1'b1) n_done++;
        end
        n_chk++; if (n_done !== (SW ? 4 : 0)) $display("FAIL sweep_pulses: got %0d want %0d", n_done, SW ? 4 : 0); else n_pass++;
    endtask

    task automatic test_midsweep_cfg();
        logic [PW-1:0] new_inc, new_off;
        bit applied, acc_now, pend_before;
        int guard, low_cnt;
        applied = 1'b0; guard = 0; low_cnt = 0;
        new_inc = $urandom; new_off = $urandom;
        send_cfg(32'h20, 32'h2, 16'd8, 32'h100);
        tick(); tick(); tick();
        cfg_valid_i = 1'b1; cfg_inc_i = new_inc; cfg_step_i = '0; cfg_len_i = '0; cfg_off_i = new_off;
        while (!applied && guard < 40) begin
            acc_now = cfg_valid_i && !m_pend;
            pend_before = m_pend;
            tick();
            guard++;
            if (acc_now) cfg_valid_i = 1'b0;
            if (cfg_ready_o === 1'b0) low_cnt++;
            n_chk++; if (cfg_ready_o !== exp_ready) $display("FAIL mid_ready: got %b want %b", cfg_ready_o, exp_ready); else n_pass++;
            n_chk++; if (valid_o !== 1'b1) $display("FAIL mid_gap: got %b want 1", valid_o); else n_pass++;
            n_chk++; if (phase_o !== exp_vec) $display("FAIL mid_phase: got %h want %h", phase_o, exp_vec); else n_pass++;
            if (pend_before && !m_pend) applied = 1'b1;
        end
        if (!applied) begin
            n_chk++;
            $display("FAIL mid_apply_timeout: got no apply, want apply within 40 clocks");
        end
        n_chk++; if (low_cnt !== (SW ? 5 : 1)) $display("FAIL mid_ready_low: got %0d want %0d", low_cnt, SW ? 5 : 1); else n_pass++;
        tick();
        n_chk++;
        if (phase_o !== lanes_of(new_off, new_inc)) $display("FAIL mid_new_cfg: got %h want %h", phase_o, lanes_of(new_off, new_inc));
        else n_pass++;
    endtask

    task automatic test_sync();
        logic [PW-1:0] inc1, off1, inc2, off2;
        inc1 = $urandom; off1 = $urandom; inc2 = $urandom; off2 = $urandom;
        send_cfg(inc1, '0, '0, off1);
        tick(); tick(); tick(); tick();
        sync_i = 1'b1; tick(); sync_i = 1'b0; tick();
        n_chk++; if (phase_o !== lanes_of(off1, inc1)) $display("FAIL sync_restart: got %h want %h", phase_o, lanes_of(off1, inc1)); else n_pass++;
        send_cfg(inc2, '0, '0, off2);
        sync_i = 1'b1; tick(); sync_i = 1'b0; tick();
        n_chk++; if (phase_o !== lanes_of(off2, inc2)) $display("FAIL sync_pending_wins: got %h want %h", phase_o, lanes_of(off2, inc2)); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cfg_valid_i = ($urandom_range(0, 3) == 0);
            cfg_inc_i   = $urandom;
            cfg_step_i  = $urandom;
            cfg_len_i   = CW'($urandom_range(0, 5));
            cfg_off_i   = $urandom;
            sync_i      = ($urandom_range(0, 15) == 0);
            tick();
            n_chk++; if (phase_o !== exp_vec) $display("FAIL rand_phase: got %h want %h", phase_o, exp_vec); else n_pass++;
            n_chk++; if (valid_o !== exp_valid) $display("FAIL rand_valid: got %b want %b", valid_o, exp_valid); else n_pass++;
            n_chk++; if (sweep_done_o !== exp_done) $display("FAIL rand_done: got %b want %b", sweep_done_o, exp_done); else n_pass++;
            n_chk++; if (cfg_ready_o !== exp_ready) $display("FAIL rand_ready: got %b want %b", cfg_ready_o, exp_ready); else n_pass++;
        end
        cfg_valid_i = 1'b0; sync_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_cfg(32'h10, 32'h1, 16'd5, '0);
        tick(); tick(); tick(); tick(); tick();
        // Pending config offered just before reset must be lost.
        cfg_valid_i = 1'b1;
        #2 rst_i = 1'b1;
        cfg_valid_i = 1'b0;
        model_reset();
        #1;
        n_chk++; if (phase_o !== '0) $display("FAIL rstmid_phase: got %h want 0", phase_o); else n_pass++;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid_o); else n_pass++;
        n_chk++; if (sweep_done_o !== 1'b0) $display("FAIL rstmid_done: got %b want 0", sweep_done_o); else n_pass++;
        n_chk++; if (cfg_ready_o !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", cfg_ready_o); else n_pass++;
        #3 rst_i = 1'b0;
        test_tone();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tone();
        test_wrap();
        test_sweep();
        test_midsweep_cfg();
        test_sync();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/phase_acc_par.md
# phase_acc_par

Parametrised multi-lane NCO phase generator: produces LANES consecutive phase samples per clock for a parallel sine lookup and DAC datapath. It extends the fixed 4-lane, constant-frequency accumulator with configurable lane count and width, a start-phase offset, and an optional repeating linear frequency sweep (chirp). A valid/ready configuration port updates it without glitching a sweep in progress.

## Interface
- LANES, 4, samples per clock, 1..16
- PHASE_W, 32, phase and increment width
- CNT_W, 16, sweep-length counter width
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- cfg_valid_i  in  1  configuration offer
- cfg_ready_o  out  1  configuration accepted when valid & ready at a rising edge
- cfg_inc_i  in  PHASE_W  start increment per sample
- cfg_step_i  in  PHASE_W  two's-complement increment delta per clock (sweep)
- cfg_len_i  in  CNT_W  sweep length in clocks; 0 = constant tone
- cfg_off_i  in  PHASE_W  start phase
- sync_i  in  1  restart phase and sweep from the active configuration
- phase_o  out  LANES*PHASE_W  lane k in bits [k*PHASE_W +: PHASE_W]
- valid_o  out  1  phase_o holds valid samples
- sweep_done_o  out  1  one-clock pulse at each sweep wrap

## Operation
- Internal registers: acc, inc, cnt, active config (inc0, step, len, off), shadow config with pending flag, state in {IDLE, TONE, SWEEP}.
- All arithmetic is modulo 2^PHASE_W. Lane k = acc + k*inc; each clock, acc <= acc + LANES*inc. Multiplies are by constants, built from shifts and adds.
- Handshake: cfg_ready_o = !pending. On acceptance the inputs go into the shadow registers and pending is set.
- Applying the shadow copy: active <= shadow, acc <= off, inc <= inc0, cnt <= len-1, pending cleared. Next state is SWEEP if len != 0, else TONE.
- Apply timing:
  - In IDLE or TONE, the shadow copy is applied on the clock after acceptance.
  - In SWEEP, it is applied at the sweep wrap only, so cfg_ready_o stays low until then.
- IDLE: after reset. valid_o = 0, acc and inc hold 0.
- TONE: inc is constant and acc advances every clock.
- SWEEP, each clock:
  - if cnt != 0: inc <= inc + step, cnt <= cnt-1.
  - if cnt == 0 (wrap): sweep_done_o pulses next cycle. Then either the pending config is applied, or inc <= inc0, cnt <= len-1 and acc keeps running (phase-continuous wrap).
  - All lanes within a clock share one inc, so the chirp is piecewise-linear with LANES-sample granularity.
- sync_i: acc <= off, inc <= inc0, cnt <= len-1. If a pending config applies on the same edge, the pending config wins. sync_i is ignored in IDLE.
- Simultaneous cfg acceptance and wrap on one edge: the config is captured now and applied at the next wrap.

## Timing
- Reset (async, immediate):
  - phase_o = 0, valid_o = 0, sweep_done_o = 0.
  - cfg_ready_o = 1, pending = 0, state = IDLE, acc/inc/cnt = 0.
- phase_o, valid_o and sweep_done_o are registered. They show the acc/inc values from the previous clock.
- Handshake at edge N (from IDLE or TONE):
  - Apply happens at edge N+1.
  - At edge N+2, phase_o lane k = off + k*inc0 and valid_o = 1.
- valid_o stays 1 from the first apply until reset.
- Reset mid-sweep aborts everything, and the pending config is lost.

## Configuration
- PHASE_ACC_SWEEP_EN defined: the SWEEP state, step and counter logic, and sweep_done_o pulses are all present.
- Not defined:
  - cfg_step_i and cfg_len_i are ignored, and the state goes only to IDLE or TONE.
  - Configs always apply on the clock after acceptance.
  - sweep_done_o is tied to 0. No step or counter registers are synthesised.

## Test plan
- Reset, then cfg inc0=0x0100_0000, off=0, len=0 (LANES=4): 2 clocks later lanes = 0x0, 0x0100_0000, 0x0200_0000, 0x0300_0000, and the next cycle lane0 = 0x0400_0000.
- Wrap-around: inc0=0x4000_0000, off=0xC000_0000, LANES=4 → lanes 0xC000_0000, 0x0, 0x4000_0000, 0x8000_0000, and acc returns to 0xC000_0000 the next cycle.
- Sweep inc0=0x10, step=0x1, len=3: inc per cycle 0x10, 0x11, 0x12, then back to 0x10. sweep_done_o pulses once every 3 cycles, and phase stays continuous across the wrap.
- Config offered mid-sweep (len=8) → cfg_ready_o low until the wrap. The new inc0 appears in phase_o 2 clocks after the wrap edge, with no sample gap.
- sync_i pulsed during TONE → phase_o restarts at off + k*inc0 two clocks later. sync_i with a simultaneous pending apply → the new config is used.
- rst_i asserted mid-sweep, asynchronous to clk_i → all outputs are 0 immediately and cfg_ready_o = 1. A repeat of the first test then passes.
